interval_capture: RTL and testbench
===================================

Name: interval_capture

Overview:
- Measures the time between two events: counts clock cycles from a `start` strobe to a `stop` strobe.
- Presents the measured interval to a consumer over a valid/ready handshake.
- Complements the timer blocks: those are loaded with an interval and generate a delay; this block observes a delay and produces the interval value.
- Used for pulse-width, echo-delay and event-spacing measurement.

Parameters:
- W, 8, counter and result width in bits; range 2..32.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin-measurement strobe, sampled on the rising clock edge.
- stop  in  1  end-measurement strobe, sampled on the rising clock edge.
- count  out  W  live elapsed-cycle counter.
- busy  out  1  high while a measurement is running.
- value  out  W  captured interval; stable while valid=1.
- overflow  out  1  captured interval saturated; qualified by valid.
- valid  out  1  result available.
- ready  in  1  consumer accepts the result.

Behaviour:
- Reset: asynchronous and active-low; applies mid-operation with no completion. While reset is low:
  - state=IDLE
  - count=0, value=0, overflow=0, valid=0, busy=0
- States: IDLE, RUN, HOLD. busy=(state==RUN). valid=(state==HOLD).
- IDLE:
  - start=1 -> RUN, count<=0, overflow-sticky<=0.
  - stop alone is ignored.
  - start and stop together: start wins, stop is ignored.
- RUN, each edge:
  - stop=1 -> value<=sat(count+1), overflow<=sticky|(count==2^W-1), state -> HOLD.
  - Otherwise, if start=1 -> restart: count<=0, sticky<=0, stay in RUN.
  - Otherwise count<=sat(count+1). If count was already 2^W-1, set sticky and hold count.
  - stop and start together: stop wins (capture); start is ignored.
- Interval definition: start sampled at edge t and stop sampled at edge t+N gives value=N, for N>=1. Saturation clamps value to 2^W-1.
- HOLD:
  - value and overflow are frozen. count is frozen at its last RUN value.
  - valid&&ready -> result consumed. If start=1 on the same edge, go directly to RUN (count<=0) for back-to-back measurement; otherwise go to IDLE.
  - start while ready=0 is dropped, not queued. stop is ignored.
- The valid/ready handshake follows the standard rule:
  - valid never drops without ready.
  - value and overflow do not change while valid=1.
  - ready may be asserted before valid; no combinational path from ready to valid.
- Latency: valid rises on the edge that samples stop (1 cycle). There are no other pipeline stages.
- Arithmetic: unsigned, W bits, saturating. No wrap-around anywhere.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- Defined:
  - Adds input port `limit` [W-1:0] and output port `timeout` [1].
  - In RUN without stop, when sat(count+1)==limit and limit!=0: capture value=limit, timeout=1, overflow=0, state -> HOLD.
  - stop on the same edge wins; the capture uses the normal rule with timeout=0.
  - limit=0 disables the timeout.
  - timeout resets to 0 and is qualified by valid.
- Undefined: ports absent; a measurement runs until stop, saturating at 2^W-1.

Decomposition:
- Shared package:
  - state encoding constants IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - localparam for the saturation maximum, derived from W.
- Natural sub-module: sat_inc (W-bit saturating incrementer with a carry/saturated flag output). Used for the count update and the capture path; reusable by other timer blocks.

Test Plan:
- W=8, ready=1. start pulse at cycle 10, stop pulse at cycle 15 -> valid=1 after edge 15, value=5, overflow=0; back to IDLE next cycle.
- W=4. start, then no stop for 20 cycles, then stop -> value=15, overflow=1; count holds at 15 from cycle 15 onward.
- ready=0 after capture of value=7, then start pulsed and 3 cycles waited -> valid held, value stays 7, start dropped. Then ready=1 together with start -> consumed, busy=1 next cycle, count=0.
- In RUN, start alone at count=6 -> count=0, still busy. Later start and stop together at count=3 -> value=4, start ignored.
- reset pulled low asynchronously mid-RUN (count=9) and mid-HOLD -> all outputs 0 immediately, before the next clock edge; state IDLE after release.
- With CAPTURE_TIMEOUT_EN, limit=12, no stop -> value=12, timeout=1, overflow=0.
- With CAPTURE_TIMEOUT_EN, limit=0 -> behaves as the macro-undefined case.

Source files
------------

// File: rtl/interval_capture_pkg.sv
// Shared definitions for the interval_capture block: FSM state encoding and
// the saturation limit used by the counter and the capture path.
package interval_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned W_DEFAULT = 8;

  function automatic logic [31:0] sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  localparam logic [W_DEFAULT-1:0] SAT_MAX_DEFAULT = W_DEFAULT'(sat_max(W_DEFAULT));

endpackage

// File: rtl/interval_capture_sat_inc.sv
// W-bit saturating incrementer: y = a+1, clamped at all-ones; sat flags that
// the input was already at the maximum.
module interval_capture_sat_inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y,
  output logic         sat
);

  always_comb begin
    sat = &a;
    y   = sat ? a : a + 1'b1;
  end

endmodule

// File: rtl/interval_capture.sv
// Measures clock cycles from a start strobe to a stop strobe and hands the
// interval over valid/ready. Optional CAPTURE_TIMEOUT_EN adds limit/timeout.
module interval_capture
  import interval_capture_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
`ifdef CAPTURE_TIMEOUT_EN
  input  logic [W-1:0] limit,
  output logic         timeout,
`endif
  output logic [W-1:0] count,
  output logic         busy,
  output logic [W-1:0] value,
  output logic         overflow,
  output logic         valid,
  input  logic         ready
);

  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));

  state_t       state, state_nx;
  logic [W-1:0] count_inc;
  logic         count_at_max;
  logic         sticky;
  logic         tmo_hit;

  interval_capture_sat_inc #(.W(W)) u_inc (
    .a   (count),
    .y   (count_inc),
    .sat (count_at_max)
  );

`ifdef CAPTURE_TIMEOUT_EN
  assign tmo_hit = (limit != '0) && (count_inc == limit);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (stop || tmo_hit) state_nx = HOLD;
      HOLD:    if (ready) state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    valid = (state == HOLD);
  end

  // Counter, sticky saturation flag and captured result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      sticky   <= 1'b0;
      value    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count  <= '0;
            sticky <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            value    <= count_inc;
            overflow <= sticky | (count == SAT_MAX);
          end else if (tmo_hit) begin
            // count_inc equals limit here, so it doubles as the captured value
            value    <= count_inc;
            overflow <= 1'b0;
          end else if (start) begin
            count  <= '0;
            sticky <= 1'b0;
          end else begin
            count <= count_inc;
            if (count_at_max) sticky <= 1'b1;
          end
        end
        HOLD: begin
          if (ready && start) begin
            count  <= '0;
            sticky <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                 timeout <= 1'b0;
    else if (state == RUN && (stop || tmo_hit)) timeout <= !stop;
  end
`endif

endmodule

// File: tb/tb_interval_capture.sv
// Directed testbench for interval_capture: a W=8 and a W=4 instance share
// stimulus; each task checks its scenario against hand-computed values.
module tb_interval_capture;

  logic       clock = 1'b0;
  logic       reset, start, stop, ready;
  logic [7:0] c8, v8;
  logic [3:0] c4, v4;
  logic       b8, o8, vl8, b4, o4, vl4;
`ifdef CAPTURE_TIMEOUT_EN
  logic [7:0] limit8;
  logic [3:0] limit4;
  logic       t8, t4;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  interval_capture #(.W(8)) u8 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
`ifdef CAPTURE_TIMEOUT_EN
    .limit(limit8), .timeout(t8),
`endif
    .count(c8), .busy(b8), .value(v8), .overflow(o8), .valid(vl8), .ready(ready)
  );

  interval_capture #(.W(4)) u4 (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
`ifdef CAPTURE_TIMEOUT_EN
    .limit(limit4), .timeout(t4),
`endif
    .count(c4), .busy(b4), .value(v4), .overflow(o4), .valid(vl4), .ready(ready)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
    limit8 = 8'd0; limit4 = 4'd0;
`endif
    #2;
    n_chk++; if ({c8, v8, o8, vl8, b8} !== 19'd0) begin n_fail++;
      $display("FAIL reset_outputs: got count=%0d value=%0d ovf=%b valid=%b busy=%b want all 0", c8, v8, o8, vl8, b8); end
    step(); step();
    reset = 1'b1;
    step();
    n_chk++; if ({c8, vl8, b8} !== 10'd0) begin n_fail++;
      $display("FAIL reset_release_idle: got count=%0d valid=%b busy=%b want 0 0 0", c8, vl8, b8); end
  endtask

  task automatic test_basic();
    start = 1'b1; step(); start = 1'b0;
    n_chk++; if (b8 !== 1'b1 || c8 !== 8'd0) begin n_fail++;
      $display("FAIL basic_run: got busy=%b count=%0d want 1 0", b8, c8); end
    repeat (4) step();
    n_chk++; if (c8 !== 8'd4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", c8); end
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (vl8 !== 1'b1 || v8 !== 8'd5 || o8 !== 1'b0 || b8 !== 1'b0) begin n_fail++;
      $display("FAIL basic_capture: got valid=%b value=%0d ovf=%b busy=%b want 1 5 0 0", vl8, v8, o8, b8); end
    n_chk++; if (c8 !== 8'd4) begin n_fail++; $display("FAIL basic_count_frozen: got %0d want 4", c8); end
    step();
    n_chk++; if (vl8 !== 1'b0 || b8 !== 1'b0) begin n_fail++;
      $display("FAIL basic_idle: got valid=%b busy=%b want 0 0", vl8, b8); end
  endtask

  task automatic test_saturate();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 14 || k == 15 || k == 19) begin
        n_chk++; if (c4 !== ((k < 15) ? 4'(k) : 4'd15)) begin n_fail++;
          $display("FAIL sat_count_k%0d: got %0d want %0d", k, c4, (k < 15) ? k : 15); end
      end
    end
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (vl4 !== 1'b1 || v4 !== 4'd15 || o4 !== 1'b1) begin n_fail++;
      $display("FAIL sat_capture_w4: got valid=%b value=%0d ovf=%b want 1 15 1", vl4, v4, o4); end
    n_chk++; if (v8 !== 8'd20 || o8 !== 1'b0) begin n_fail++;
      $display("FAIL sat_capture_w8: got value=%0d ovf=%b want 20 0", v8, o8); end
    step();
  endtask

  task automatic test_hold();
    ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (vl8 !== 1'b1 || v8 !== 8'd7) begin n_fail++;
      $display("FAIL hold_capture: got valid=%b value=%0d want 1 7", vl8, v8); end
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    n_chk++; if (vl8 !== 1'b1 || v8 !== 8'd7 || b8 !== 1'b0) begin n_fail++;
      $display("FAIL hold_stall: got valid=%b value=%0d busy=%b want 1 7 0", vl8, v8, b8); end
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (vl8 !== 1'b1 || v8 !== 8'd7) begin n_fail++;
      $display("FAIL hold_stop_ignored: got valid=%b value=%0d want 1 7", vl8, v8); end
    ready = 1'b1; start = 1'b1; step(); start = 1'b0;
    n_chk++; if (vl8 !== 1'b0 || b8 !== 1'b1 || c8 !== 8'd0) begin n_fail++;
      $display("FAIL hold_back_to_back: got valid=%b busy=%b count=%0d want 0 1 0", vl8, b8, c8); end
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (vl8 !== 1'b1 || v8 !== 8'd1) begin n_fail++;
      $display("FAIL hold_b2b_capture: got valid=%b value=%0d want 1 1", vl8, v8); end
    step();
  endtask

  task automatic test_restart();
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (vl8 !== 1'b0 || b8 !== 1'b0) begin n_fail++;
      $display("FAIL idle_stop_ignored: got valid=%b busy=%b want 0 0", vl8, b8); end
    start = 1'b1; step(); start = 1'b0;
    repeat (6) step();
    n_chk++; if (c8 !== 8'd6) begin n_fail++; $display("FAIL restart_pre: got %0d want 6", c8); end
    start = 1'b1; step(); start = 1'b0;
    n_chk++; if (c8 !== 8'd0 || b8 !== 1'b1) begin n_fail++;
      $display("FAIL restart_clear: got count=%0d busy=%b want 0 1", c8, b8); end
    repeat (3) step();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_chk++; if (vl8 !== 1'b1 || v8 !== 8'd4 || b8 !== 1'b0) begin n_fail++;
      $display("FAIL run_stop_wins: got valid=%b value=%0d busy=%b want 1 4 0", vl8, v8, b8); end
    step();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    n_chk++; if (b8 !== 1'b1 || vl8 !== 1'b0 || c8 !== 8'd0) begin n_fail++;
      $display("FAIL idle_start_wins: got busy=%b valid=%b count=%0d want 1 0 0", b8, vl8, c8); end
    stop = 1'b1; step(); stop = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    start = 1'b1; step(); start = 1'b0;
    repeat (9) step();
    n_chk++; if (c8 !== 8'd9) begin n_fail++; $display("FAIL areset_pre_count: got %0d want 9", c8); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if ({c8, v8, o8, vl8, b8} !== 19'd0) begin n_fail++;
      $display("FAIL areset_run: got count=%0d value=%0d ovf=%b valid=%b busy=%b want all 0", c8, v8, o8, vl8, b8); end
    #2 reset = 1'b1;
    step();
    n_chk++; if (b8 !== 1'b0 || vl8 !== 1'b0) begin n_fail++;
      $display("FAIL areset_run_idle: got busy=%b valid=%b want 0 0", b8, vl8); end
    ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (2) step();
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (vl8 !== 1'b1 || v8 !== 8'd3) begin n_fail++;
      $display("FAIL areset_pre_hold: got valid=%b value=%0d want 1 3", vl8, v8); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if ({c8, v8, o8, vl8, b8} !== 19'd0 || {c4, v4, o4, vl4, b4} !== 11'd0) begin n_fail++;
      $display("FAIL areset_hold: got count=%0d value=%0d ovf=%b valid=%b busy=%b want all 0", c8, v8, o8, vl8, b8); end
    #2 reset = 1'b1;
    ready = 1'b1;
    step();
    n_chk++; if (vl8 !== 1'b0 || b8 !== 1'b0) begin n_fail++;
      $display("FAIL areset_hold_idle: got valid=%b busy=%b want 0 0", vl8, b8); end
  endtask

`ifdef CAPTURE_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    limit8 = 8'd12; limit4 = 4'd12;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (vl8 !== 1'b1 && n < 20) begin step(); n++; end
    n_chk++; if (n !== 12) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles want 12", n); end
    n_chk++; if (vl8 !== 1'b1 || v8 !== 8'd12 || t8 !== 1'b1 || o8 !== 1'b0) begin n_fail++;
      $display("FAIL tmo_capture: got valid=%b value=%0d tmo=%b ovf=%b want 1 12 1 0", vl8, v8, t8, o8); end
    step();
    limit8 = 8'd0; limit4 = 4'd0;
    start = 1'b1; step(); start = 1'b0;
    repeat (20) step();
    n_chk++; if (vl8 !== 1'b0 || b8 !== 1'b1) begin n_fail++;
      $display("FAIL tmo_disabled_run: got valid=%b busy=%b want 0 1", vl8, b8); end
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (v8 !== 8'd21 || t8 !== 1'b0 || v4 !== 4'd15 || o4 !== 1'b1 || t4 !== 1'b0) begin n_fail++;
      $display("FAIL tmo_disabled_capture: got v8=%0d t8=%b v4=%0d o4=%b t4=%b want 21 0 15 1 0", v8, t8, v4, o4, t4); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_hold();
    test_restart();
    test_async_reset();
`ifdef CAPTURE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
